// File: rtl/fb_pattern_writer.sv
// Wishbone write master that fills the SDRAM framebuffer with a test pattern.
// Define MIRE_CONTINUOUS_EN to refill frames back-to-back instead of single-shot.
module fb_pattern_writer #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int BURST_LEN  = 64,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  input  logic [31:0] dat_sm,
  input  logic        ack,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [3:0]  sel,
  output logic [2:0]  cti,
  output logic [1:0]  bte
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic [BW-1:0] bcnt;
  logic [GW-1:0] gcnt;
  logic [1:0]    sel_lat;
  logic [23:0]   rgb_lat;
  logic          last_px;
  logic          unused_dat;

  // Colour-bar index from a compare chain against the k*HDISP/8 band edges.
  function automatic logic [2:0] bar_band(input logic [XW-1:0] px);
    logic [2:0] band;
    band = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (px >= XW'(k * HDISP / 8)) band = 3'(k);
    end
    return band;
  endfunction

  function automatic logic [31:0] pixel(input logic [1:0] psel, input logic [23:0] prgb,
                                        input logic [XW-1:0] px, input logic [YW-1:0] py);
    logic [31:0] xe;
    logic [31:0] ye;
    logic [2:0]  band;
    logic [7:0]  lvl;
    xe   = 32'(px);
    ye   = 32'(py);
    band = bar_band(px);
    lvl  = xe[7:0];
    case (psel)
      2'd0:    return (xe[3:0] == 4'd0 || ye[3:0] == 4'd0) ? 32'h00FF_FFFF : 32'h0;
      2'd1:    return {8'h00, lvl, lvl, lvl};
      2'd2:    return {8'h00, prgb};
      default: return {8'h00, {8{band[2]}}, {8{band[1]}}, {8{band[0]}}};
    endcase
  endfunction

  always_comb begin
    x_nxt = x + 1'b1;
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = y + 1'b1;
    end
  end

  assign last_px    = (x == X_LAST) && (y == Y_LAST);
  assign cyc        = stb;
  assign we         = 1'b1;
  assign sel        = 4'b1111;
  assign cti        = 3'b000;
  assign bte        = 2'b00;
  assign unused_dat = ^dat_sm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stb       <= 1'b0;
      adr       <= 32'h0;
      dat_ms    <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 16'h0;
      x         <= '0;
      y         <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      sel_lat   <= 2'd0;
      rgb_lat   <= 24'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_lat <= pattern_sel;
            rgb_lat <= solid_rgb;
            x       <= '0;
            y       <= '0;
            adr     <= 32'h0;
            bcnt    <= '0;
            dat_ms  <= pixel(pattern_sel, solid_rgb, '0, '0);
            busy    <= 1'b1;
            stb     <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (ack && stb) begin
            // End of frame wins over the burst-release check.
            if (last_px) begin
              x         <= '0;
              y         <= '0;
              adr       <= 32'h0;
              bcnt      <= '0;
              frame_cnt <= frame_cnt + 16'd1;
              done      <= 1'b1;
              stb       <= 1'b0;
`ifdef MIRE_CONTINUOUS_EN
              sel_lat   <= pattern_sel;
              rgb_lat   <= solid_rgb;
              dat_ms    <= pixel(pattern_sel, solid_rgb, '0, '0);
              gcnt      <= '0;
              state     <= GAP;
`else
              dat_ms    <= pixel(sel_lat, rgb_lat, '0, '0);
              busy      <= 1'b0;
              state     <= IDLE;
`endif
            end else begin
              x      <= x_nxt;
              y      <= y_nxt;
              adr    <= adr + 32'd4;
              dat_ms <= pixel(sel_lat, rgb_lat, x_nxt, y_nxt);
              if (bcnt == B_LAST) begin
                bcnt  <= '0;
                gcnt  <= '0;
                stb   <= 1'b0;
                state <= GAP;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (gcnt == G_LAST) begin
            gcnt  <= '0;
            stb   <= 1'b1;
            state <= WRITE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
